udp_tx_arbiter: RTL and testbench
=================================

# udp_tx_arbiter

Shares the single UDP transmit port of the Ethernet core between two packet requesters: requester 0 is the RTP audio packetizer and requester 1 is a low-rate control/status source. Each granted packet is latched, presented on the UDP send interface, and held until the core's one-cycle completion pulse or a timeout. Audio has fixed priority, with a starvation guard for the control source. Sits between the packetizer/control logic and the Ethernet test core in the 50 MHz domain.

## Interface
- DATA_W, 7680, payload bus width in bits (960 bytes × 8)
- LEN_W, 16, length field width in bytes
- STARVE_MAX, 4, consecutive req0 grants allowed while req1 waits
- GAP_CYC, 16, idle cycles enforced after each packet (0 allowed)
- TIMEOUT_CYC, 1000000, cycles to wait for completion before abort

- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- reqN_valid  in  1  (N=0,1) packet pending; held until reqN_ack
- reqN_data  in  DATA_W  packet payload, byte 0 in MSBs
- reqN_length  in  LEN_W  payload length in bytes
- reqN_ack  out  1  one-cycle pulse: packet latched, requester may change inputs
- reqN_done  out  1  one-cycle pulse: packet completed or aborted
- udp_send_data_valid  out  1  level, packet presented to core
- udp_send_data  out  DATA_W  latched payload
- udp_send_data_length  out  LEN_W  latched length
- udp_send_data_ready  in  1  one-cycle completion pulse from core
- grant_id  out  1  requester owning current/last packet
- busy  out  1  state ≠ IDLE
- err_pulse  out  1  one-cycle pulse on reject or timeout
- drop_cnt  out  8  saturating count of rejects + timeouts

## Operation
- States: IDLE, SEND, GAP.
- IDLE: arbitrate when any reqN_valid is high.
  - Only one valid: grant it.
  - Both valid: grant req0 unless starve_cnt == STARVE_MAX, then grant req1.
- starve_cnt (width ≥ clog2(STARVE_MAX+1)):
  - +1 on a req0 grant while req1_valid.
  - Cleared on a req1 grant, or on a req0 grant while req1 is not valid.
- On grant:
  - Latch data and length into output registers; set grant_id; pulse reqN_ack.
- Length check:
  - Length 0 or > DATA_W/8: reject. Ack, done and err_pulse all pulse in the same cycle, drop_cnt increments, and the state goes to GAP.
  - Otherwise the state goes to SEND.
- SEND:
  - udp_send_data_valid = 1; timeout counter increments each cycle.
  - On udp_send_data_ready: deassert valid, pulse reqN_done for grant_id, then go to GAP.
  - If the counter reaches TIMEOUT_CYC-1 without ready: deassert valid, pulse done and err_pulse, increment drop_cnt, then go to GAP.
- GAP: count GAP_CYC cycles, then go to IDLE. With GAP_CYC = 0, go from SEND straight to IDLE.
- udp_send_data_ready outside SEND is ignored.
- drop_cnt saturates at 255.
- Reset (any state, including mid-packet):
  - State → IDLE; valid, ack, done, err_pulse, busy, grant_id → 0.
  - starve_cnt, drop_cnt and counters → 0; udp_send_data and length → 0.
  - An in-flight packet is abandoned with no done pulse.

## Timing
- All outputs are registered.
- Request sampled high in IDLE at edge N: at N+1, reqN_ack = 1, udp_send_data_valid = 1 and data/length are valid.
- udp_send_data_valid stays high continuously from N+1 through the cycle in which ready is sampled.
- Ready sampled at edge M: at M+1, valid = 0 and reqN_done = 1; GAP runs M+1..M+GAP_CYC.
- Earliest next ack is at M+GAP_CYC+1.
- A request that stays valid after its ack is treated as a new packet at the next IDLE. Requesters must drop valid in the ack cycle.
- Data and length are stable for the whole SEND interval, regardless of requester inputs.
- Ready arriving in the first SEND cycle (N+1) is accepted; done is at N+2.
- Timeout: valid is high for exactly TIMEOUT_CYC cycles, then done and err_pulse are at the following edge.

## Test plan
- Single req0, length 960, ready pulsed 20 cycles after valid → ack at N+1; valid high 21 cycles; done 1 cycle after ready; no next ack before GAP_CYC = 16 idle cycles.
- req0 and req1 held continuously, STARVE_MAX = 4 → grant sequence 0,0,0,0,1,0,0,0,0,1.
- req1 with length 0, then with length 961 → two immediate ack+done+err pulses; drop_cnt = 2; udp_send_data_valid never asserted.
- req0 with ready never pulsed, TIMEOUT_CYC = 100 → valid high exactly 100 cycles; done and err_pulse at cycle 101; drop_cnt +1; the next request is served normally.
- Change req0_data immediately after ack → udp_send_data unchanged through SEND. A ready pulse injected during IDLE/GAP has no effect.
- Assert rst mid-SEND → next cycle: valid = 0, busy = 0, no done pulse, drop_cnt = 0; a fresh request after rst release is acked at N+1.

Source files
------------

// File: rtl/udp_tx_arbiter_if.sv
// Request/acknowledge signals of the two packet sources plus the UDP send port of
// the Ethernet core. The arbiter takes the master side; sources and core take the slave side.
interface udp_tx_arbiter_if #(
   parameter int DATA_W = 7680,
   parameter int LEN_W  = 16
);
   logic              req0_valid;
   logic [DATA_W-1:0] req0_data;
   logic [LEN_W-1:0]  req0_length;
   logic              req0_ack;
   logic              req0_done;

   logic              req1_valid;
   logic [DATA_W-1:0] req1_data;
   logic [LEN_W-1:0]  req1_length;
   logic              req1_ack;
   logic              req1_done;

   logic              udp_send_data_valid;
   logic [DATA_W-1:0] udp_send_data;
   logic [LEN_W-1:0]  udp_send_data_length;
   logic              udp_send_data_ready;

   modport master (
      input  req0_valid, req0_data, req0_length,
      input  req1_valid, req1_data, req1_length,
      input  udp_send_data_ready,
      output req0_ack, req0_done, req1_ack, req1_done,
      output udp_send_data_valid, udp_send_data, udp_send_data_length
   );

   modport slave (
      output req0_valid, req0_data, req0_length,
      output req1_valid, req1_data, req1_length,
      output udp_send_data_ready,
      input  req0_ack, req0_done, req1_ack, req1_done,
      input  udp_send_data_valid, udp_send_data, udp_send_data_length
   );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Two-source arbiter for the single UDP transmit port: audio (req0) has fixed priority,
// control (req1) is guaranteed a slot after STARVE_MAX back-to-back audio grants.
module udp_tx_arbiter #(
   parameter int DATA_W      = 7680,
   parameter int LEN_W       = 16,
   parameter int STARVE_MAX  = 4,
   parameter int GAP_CYC     = 16,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   udp_tx_arbiter_if.master bus,
   output logic             grant_id,
   output logic             busy,
   output logic             err_pulse,
   output logic [7:0]       drop_cnt
);
   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

   localparam int MAX_LEN  = DATA_W / 8;
   localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
   localparam logic [GAP_W-1:0]    GAP_LAST   = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
   localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   // Where a finished or rejected packet goes: with no gap the port is free at once.
   localparam state_t POST_ST = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;

   state_t              state_q, state_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                grant_q, grant_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [7:0]          drop_q, drop_d;
   logic                busy_q, busy_d;
   logic                ack0_q, ack0_d, ack1_q, ack1_d;
   logic                done0_q, done0_d, done1_q, done1_d;
   logic                err_q, err_d;

   logic arb_en, pick1, pkt_end, pkt_err;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic len_ok(input logic [LEN_W-1:0] len);
      return (len != '0) && (32'(len) <= 32'(MAX_LEN));
   endfunction

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      gap_d    = gap_q;
      tmo_d    = tmo_q;
      grant_d  = grant_q;
      valid_d  = valid_q;
      data_d   = data_q;
      len_d    = len_q;
      drop_d   = drop_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      err_d    = 1'b0;
      arb_en   = 1'b0;
      pick1    = 1'b0;
      pkt_end  = 1'b0;
      pkt_err  = 1'b0;

      case (state_q)
         ST_IDLE: arb_en = 1'b1;
         ST_SEND: begin
            if (bus.udp_send_data_ready) begin
               pkt_end = 1'b1;
            end else if (tmo_q == TMO_LAST) begin
               pkt_end = 1'b1;
               pkt_err = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_GAP: begin
            // The last gap cycle already arbitrates so the next ack lands right after the gap.
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
               arb_en  = 1'b1;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pkt_end) begin
         valid_d = 1'b0;
         done0_d = ~grant_q;
         done1_d = grant_q;
         err_d   = pkt_err;
         if (pkt_err) drop_d = sat_inc(drop_q);
         gap_d   = '0;
         state_d = POST_ST;
      end

      if (arb_en && (bus.req0_valid || bus.req1_valid)) begin
         pick1 = bus.req1_valid && (!bus.req0_valid || starve_q == STARVE_LIM);
         if (pick1 || !bus.req1_valid) starve_d = '0;
         else                          starve_d = starve_q + 1'b1;
         grant_d = pick1;
         ack0_d  = ~pick1;
         ack1_d  = pick1;
         data_d  = pick1 ? bus.req1_data   : bus.req0_data;
         len_d   = pick1 ? bus.req1_length : bus.req0_length;
         if (len_ok(len_d)) begin
            state_d = ST_SEND;
            valid_d = 1'b1;
            tmo_d   = '0;
         end else begin
            // Rejected packets complete in the ack cycle and still observe the gap.
            done0_d = ~pick1;
            done1_d = pick1;
            err_d   = 1'b1;
            drop_d  = sat_inc(drop_q);
            gap_d   = '0;
            state_d = POST_ST;
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         starve_q <= '0;
         gap_q    <= '0;
         tmo_q    <= '0;
         grant_q  <= 1'b0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         len_q    <= '0;
         drop_q   <= '0;
         busy_q   <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         gap_q    <= gap_d;
         tmo_q    <= tmo_d;
         grant_q  <= grant_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         len_q    <= len_d;
         drop_q   <= drop_d;
         busy_q   <= busy_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         err_q    <= err_d;
      end
   end

   assign bus.req0_ack             = ack0_q;
   assign bus.req1_ack             = ack1_q;
   assign bus.req0_done            = done0_q;
   assign bus.req1_done            = done1_q;
   assign bus.udp_send_data_valid  = valid_q;
   assign bus.udp_send_data        = data_q;
   assign bus.udp_send_data_length = len_q;
   assign grant_id                 = grant_q;
   assign busy                     = busy_q;
   assign err_pulse                = err_q;
   assign drop_cnt                 = drop_q;
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed sequence with randomized payloads, lengths and ready delays, checked against
// timing and arbitration expectations computed from the arbiter's rules.
module tb_udp_tx_arbiter;
   localparam int DATA_W      = 7680;
   localparam int LEN_W       = 16;
   localparam int STARVE_MAX  = 4;
   localparam int GAP_CYC     = 16;
   localparam int TIMEOUT_CYC = 100;
   localparam int MAX_LEN     = DATA_W / 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       grant_id, busy, err_pulse;
   logic [7:0] drop_cnt;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int done_cyc    = -1000;
   int drop_model  = 0;

   udp_tx_arbiter_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

   udp_tx_arbiter #(
      .DATA_W(DATA_W), .LEN_W(LEN_W), .STARVE_MAX(STARVE_MAX),
      .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .grant_id(grant_id), .busy(busy), .err_pulse(err_pulse), .drop_cnt(drop_cnt)
   );

   always #10 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed low word %h expected low word %h", tag, obs[63:0], exp[63:0]);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic ack_of(input int id);
      return (id != 0) ? bus.req1_ack : bus.req0_ack;
   endfunction

   function automatic logic done_of(input int id);
      return (id != 0) ? bus.req1_done : bus.req0_done;
   endfunction

   task automatic set_req(input int id, input logic v, input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] l);
      if (id == 0) begin
         bus.req0_valid = v; bus.req0_data = d; bus.req0_length = l;
      end else begin
         bus.req1_valid = v; bus.req1_data = d; bus.req1_length = l;
      end
   endtask

   function automatic int bad_len();
      return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 65535));
   endfunction

   // One packet from one requester; delay < 0 means the core never answers.
   task automatic run_packet(input int id, input logic [DATA_W-1:0] data, input int len, input int delay);
      int   r, exp_a, vcnt, exp_v;
      logic seen, stable, ok_len;
      ok_len = (len >= 1) && (len <= MAX_LEN);
      set_req(id, 1'b1, data, LEN_W'(len));
      r    = cyc;
      seen = 1'b0;
      for (int k = 0; k < 64 && !seen; k++) begin
         tick();
         if (bus.req0_ack || bus.req1_ack) seen = 1'b1;
      end
      set_req(id, 1'b0, rand_data(), LEN_W'($urandom));
      chk("ack_seen", 64'(seen), 64'd1);
      if (!seen) return;
      exp_a = (r + 1 > done_cyc + GAP_CYC) ? r + 1 : done_cyc + GAP_CYC;
      chk("ack_cycle", 64'(cyc), 64'(exp_a));
      chk("ack_id", 64'(ack_of(id)), 64'd1);
      chk("ack_other", 64'(ack_of(1 - id)), 64'd0);
      chk("grant_id", 64'(grant_id), 64'(id));
      chk_w("latched_data", bus.udp_send_data, data);
      chk("latched_len", 64'(bus.udp_send_data_length), 64'(len));
      chk("busy_grant", 64'(busy), 64'd1);
      if (!ok_len) begin
         drop_model = (drop_model < 255) ? drop_model + 1 : 255;
         chk("reject_valid", 64'(bus.udp_send_data_valid), 64'd0);
         chk("reject_done", 64'(done_of(id)), 64'd1);
         chk("reject_err", 64'(err_pulse), 64'd1);
         chk("reject_drop", 64'(drop_cnt), 64'(drop_model));
         done_cyc = cyc;
         return;
      end
      chk("send_valid", 64'(bus.udp_send_data_valid), 64'd1);
      chk("send_nodone", 64'(done_of(id)), 64'd0);
      vcnt   = 1;
      stable = 1'b1;
      for (int k = 0; k < TIMEOUT_CYC + 8; k++) begin
         bus.udp_send_data_ready = (k == delay);
         tick();
         bus.udp_send_data_ready = 1'b0;
         if (!bus.udp_send_data_valid) break;
         vcnt++;
         if (bus.udp_send_data !== data || bus.udp_send_data_length !== LEN_W'(len)) stable = 1'b0;
      end
      exp_v = (delay < 0) ? TIMEOUT_CYC : delay + 1;
      if (delay < 0) drop_model = (drop_model < 255) ? drop_model + 1 : 255;
      chk("valid_cycles", 64'(vcnt), 64'(exp_v));
      chk("data_stable", 64'(stable), 64'd1);
      chk("done_id", 64'(done_of(id)), 64'd1);
      chk("done_other", 64'(done_of(1 - id)), 64'd0);
      chk("done_err", 64'(err_pulse), 64'(delay < 0));
      chk("done_drop", 64'(drop_cnt), 64'(drop_model));
      chk("busy_gap", 64'(busy), 64'd1);
      done_cyc = cyc;
   endtask

   task automatic ready_noise(input int n, input string tag);
      logic quiet;
      quiet = 1'b1;
      for (int i = 0; i < n; i++) begin
         bus.udp_send_data_ready = 1'($urandom_range(0, 1));
         tick();
         bus.udp_send_data_ready = 1'b0;
         if (bus.req0_done || bus.req1_done || err_pulse || bus.udp_send_data_valid ||
             bus.req0_ack || bus.req1_ack) quiet = 1'b0;
      end
      chk(tag, 64'(quiet), 64'd1);
   endtask

   initial begin
      logic              seen, quiet;
      int                expg, d;
      logic [DATA_W-1:0] d0, d1;

      rst = 1'b1;
      bus.udp_send_data_ready = 1'b0;
      set_req(0, 1'b0, '0, '0);
      set_req(1, 1'b0, '0, '0);
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_valid", 64'(bus.udp_send_data_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant", 64'(grant_id), 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_acks", 64'({bus.req0_ack, bus.req1_ack, bus.req0_done, bus.req1_done, err_pulse}), 64'd0);
      chk_w("rst_data", bus.udp_send_data, '0);
      chk("rst_len", 64'(bus.udp_send_data_length), 64'd0);

      // Full-size audio packet answered 20 cycles after valid, then ready noise inside the gap
      run_packet(0, rand_data(), MAX_LEN, 20);
      ready_noise(6, "gap_ready_ignored");

      // Control packets with illegal lengths
      run_packet(1, rand_data(), 0, 0);
      run_packet(1, rand_data(), MAX_LEN + 1, 0);
      chk("drop_after_rejects", 64'(drop_cnt), 64'd2);

      // Core never answers, then a normal packet
      run_packet(0, rand_data(), int'($urandom_range(1, MAX_LEN)), -1);
      run_packet(1, rand_data(), int'($urandom_range(1, MAX_LEN)), 3);
      repeat (GAP_CYC + 4) tick();
      ready_noise(5, "idle_ready_ignored");

      // Both sources held continuously
      d0 = rand_data();
      d1 = rand_data();
      set_req(0, 1'b1, d0, LEN_W'(100));
      set_req(1, 1'b1, d1, LEN_W'(200));
      for (int g = 0; g < 10; g++) begin
         seen = 1'b0;
         for (int k = 0; k < 64 && !seen; k++) begin
            tick();
            if (bus.req0_ack || bus.req1_ack) seen = 1'b1;
         end
         chk("starve_ack_seen", 64'(seen), 64'd1);
         expg = ((g % (STARVE_MAX + 1)) == STARVE_MAX) ? 1 : 0;
         chk("starve_grant", 64'(grant_id), 64'(expg));
         chk("starve_ack", 64'(ack_of(expg)), 64'd1);
         if (g == 9) begin
            set_req(0, 1'b0, d0, LEN_W'(100));
            set_req(1, 1'b0, d1, LEN_W'(200));
         end
         d = int'($urandom_range(0, 5));
         for (int k = 0; k < TIMEOUT_CYC + 8; k++) begin
            bus.udp_send_data_ready = (k == d);
            tick();
            bus.udp_send_data_ready = 1'b0;
            if (!bus.udp_send_data_valid) break;
         end
         chk("starve_done", 64'(done_of(expg)), 64'd1);
         done_cyc = cyc;
      end

      // Random traffic
      for (int p = 0; p < 12; p++) begin
         run_packet(int'($urandom_range(0, 1)), rand_data(),
                    ($urandom_range(0, 5) == 0) ? bad_len() : int'($urandom_range(1, MAX_LEN)),
                    ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 40)));
      end

      // Reset in the middle of a packet
      set_req(0, 1'b1, rand_data(), LEN_W'(500));
      seen = 1'b0;
      for (int k = 0; k < 64 && !seen; k++) begin
         tick();
         if (bus.req0_ack) seen = 1'b1;
      end
      set_req(0, 1'b0, '0, '0);
      chk("midsend_ack_seen", 64'(seen), 64'd1);
      repeat (3) tick();
      chk("midsend_valid", 64'(bus.udp_send_data_valid), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drop_model = 0;
      done_cyc   = -1000;
      chk("midrst_valid", 64'(bus.udp_send_data_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_drop", 64'(drop_cnt), 64'd0);
      chk("midrst_grant", 64'(grant_id), 64'd0);
      quiet = ~(bus.req0_done | bus.req1_done | err_pulse);
      repeat (3) begin
         tick();
         if (bus.req0_done || bus.req1_done || err_pulse) quiet = 1'b0;
      end
      chk("midrst_no_done", 64'(quiet), 64'd1);
      run_packet(1, rand_data(), int'($urandom_range(1, MAX_LEN)), int'($urandom_range(0, 10)));

      // Enough rejects to saturate the drop counter
      for (int p = 0; p < 258; p++) begin
         run_packet(int'($urandom_range(0, 1)), rand_data(), bad_len(), 0);
      end
      chk("drop_saturated", 64'(drop_cnt), 64'd255);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
